param_bit_counter: RTL and testbench

Parametrised successor to the team's 8-bit clear/increment bit counter. Adds configurable width and modulus, and up/down counting. Also adds parallel load, an input prescaler, wrap-or-saturate mode, terminal flags and sticky overflow/underflow. Used wherever datapath control needs an event or bit counter with a modulus other than 2^8.

---
 rtl/param_bit_counter_if.sv | 42 ++++
 rtl/param_bit_counter.sv | 174 +++++++++++++++++
 tb/tb_param_bit_counter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_bit_counter_if.sv
// Bus interface for param_bit_counter: control strobes, load value and the
// counter's status outputs. clk and reset are kept as plain module ports.
// Optional macro PARAM_BIT_COUNTER_SNAPSHOT_EN adds snap/snapshot.
interface param_bit_counter_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             inc;
  logic             dec;
  logic             load;
  logic [WIDTH-1:0] loadValue;
  logic [WIDTH-1:0] count;
  logic             atMax;
  logic             atZero;
  logic             wrapPulse;
  logic             overflow;
  logic             underflow;
`ifdef PARAM_BIT_COUNTER_SNAPSHOT_EN
  logic             snap;
  logic [WIDTH-1:0] snapshot;

  modport master (
    output clear, inc, dec, load, loadValue, snap,
    input  count, atMax, atZero, wrapPulse, overflow, underflow, snapshot
  );

  modport slave (
    input  clear, inc, dec, load, loadValue, snap,
    output count, atMax, atZero, wrapPulse, overflow, underflow, snapshot
  );
`else
  modport master (
    output clear, inc, dec, load, loadValue,
    input  count, atMax, atZero, wrapPulse, overflow, underflow
  );

  modport slave (
    input  clear, inc, dec, load, loadValue,
    output count, atMax, atZero, wrapPulse, overflow, underflow
  );
`endif
endinterface

// File: rtl/param_bit_counter.sv
// param_bit_counter: parametrised up/down event counter with modulus
// MAX_COUNT+1, shared input prescaler, parallel load, wrap-or-saturate
// terminal handling, one-cycle wrap pulse and sticky overflow/underflow.
// Optional macro PARAM_BIT_COUNTER_SNAPSHOT_EN adds a snap strobe that
// captures the pre-update count into a snapshot register.
module param_bit_counter #(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 255,
  parameter int          PRESCALE  = 1,
  parameter bit          SATURATE  = 1'b0
) (
  input logic            clk,
  input logic            reset,
  param_bit_counter_if.slave bus
);

  // Prescaler needs at least one bit even when it never advances.
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  if ((WIDTH < 2) || (WIDTH > 32)) begin : gBadWidth
    $error("param_bit_counter: WIDTH must be 2..32");
  end
  if ((MAX_COUNT < 1) ||
      (longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1))) begin : gBadMax
    $error("param_bit_counter: MAX_COUNT must be 1..2^WIDTH-1");
  end
  if ((PRESCALE < 1) || (PRESCALE > 256)) begin : gBadPrescale
    $error("param_bit_counter: PRESCALE must be 1..256");
  end

  // Result of one count step: new value, whether it wrapped, and whether a
  // terminal was hit (drives the sticky flags in both modes).
  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             wrap;
    logic             hitLimit;
  } stepT;

  logic [WIDTH-1:0] countReg;
  logic [WIDTH-1:0] countNext;
  logic [PW-1:0]    preReg;
  logic [PW-1:0]    preNext;
  logic             wrapReg;
  logic             wrapNext;
  logic             ovReg;
  logic             ovNext;
  logic             unReg;
  logic             unNext;
  logic             upEvt;
  logic             dnEvt;
  stepT             stepRes;

  // Loaded values above the modulus are clamped to the terminal count.
  function automatic logic [WIDTH-1:0] clampLoad(input logic [WIDTH-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Up step: at MAX_COUNT either wrap to 0 or hold, depending on SATURATE.
  function automatic stepT stepUp(input logic [WIDTH-1:0] cur);
    stepT r;
    r.value    = cur;
    r.wrap     = 1'b0;
    r.hitLimit = 1'b0;
    if (cur == MAXV) begin
      r.hitLimit = 1'b1;
      if (!SATURATE) begin
        r.value = '0;
        r.wrap  = 1'b1;
      end
    end else begin
      r.value = cur + WIDTH'(1);
    end
    return r;
  endfunction

  // Down step: at 0 either wrap to MAX_COUNT or hold, depending on SATURATE.
  function automatic stepT stepDown(input logic [WIDTH-1:0] cur);
    stepT r;
    r.value    = cur;
    r.wrap     = 1'b0;
    r.hitLimit = 1'b0;
    if (cur == '0) begin
      r.hitLimit = 1'b1;
      if (!SATURATE) begin
        r.value = MAXV;
        r.wrap  = 1'b1;
      end
    end else begin
      r.value = cur - WIDTH'(1);
    end
    return r;
  endfunction

  // Stage p0: event qualification; simultaneous inc and dec cancel out.
  assign upEvt = bus.inc & ~bus.dec;
  assign dnEvt = bus.dec & ~bus.inc;

  // Next-state selection with priority clear > load > prescaled step.
  always_comb begin
    countNext = countReg;
    preNext   = preReg;
    ovNext    = ovReg;
    unNext    = unReg;
    wrapNext  = 1'b0;
    stepRes   = '0;
    if (bus.clear) begin
      countNext = '0;
      preNext   = '0;
      ovNext    = 1'b0;
      unNext    = 1'b0;
    end else if (bus.load) begin
      countNext = clampLoad(bus.loadValue);
      preNext   = '0;
    end else if (upEvt || dnEvt) begin
      if (preReg == PRE_LAST) begin
        preNext   = '0;
        stepRes   = upEvt ? stepUp(countReg) : stepDown(countReg);
        countNext = stepRes.value;
        wrapNext  = stepRes.wrap;
        if (stepRes.hitLimit) begin
          if (upEvt) begin
            ovNext = 1'b1;
          end else begin
            unNext = 1'b1;
          end
        end
      end else begin
        preNext = preReg + PW'(1);
      end
    end
  end

  // Stage p1: state registers; reset clears all state including the partial prescale.
  always_ff @(posedge clk) begin
    if (!reset) begin
      countReg <= '0;
      preReg   <= '0;
      wrapReg  <= 1'b0;
      ovReg    <= 1'b0;
      unReg    <= 1'b0;
    end else begin
      countReg <= countNext;
      preReg   <= preNext;
      wrapReg  <= wrapNext;
      ovReg    <= ovNext;
      unReg    <= unNext;
    end
  end

`ifdef PARAM_BIT_COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0] snapReg;

  // Snapshot captures the count visible during the snap cycle; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snapReg <= '0;
    end else if (bus.snap) begin
      snapReg <= countReg;
    end
  end

  assign bus.snapshot = snapReg;
`endif

  assign bus.count     = countReg;
  assign bus.atMax     = (countReg == MAXV);
  assign bus.atZero    = (countReg == '0);
  assign bus.wrapPulse = wrapReg;
  assign bus.overflow  = ovReg;
  assign bus.underflow = unReg;

endmodule

// File: tb/tb_param_bit_counter.sv
// Self-checking bench for param_bit_counter. Four instances with different
// MAX_COUNT / PRESCALE / SATURATE settings share one stimulus stream and are
// compared every cycle against an arithmetic reference model.
module tb_param_bit_counter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       inc;
  logic       dec;
  logic       load;
  logic       snap;
  logic [7:0] loadValue;

  always #5 clk = ~clk;

  function automatic int mxOf(input int i);
    return (i == 0) ? 255 : 9;
  endfunction

  function automatic int preOf(input int i);
    return (i == 3) ? 3 : 1;
  endfunction

  function automatic bit satOf(input int i);
    return (i == 2);
  endfunction

  logic [7:0] dCount[N];
  logic       dAtMax[N];
  logic       dAtZero[N];
  logic       dWp[N];
  logic       dOv[N];
  logic       dUn[N];
  logic [7:0] dSnap[N];

  for (genvar g = 0; g < N; g++) begin : gDut
    param_bit_counter_if #(.WIDTH(8)) bus ();

    assign bus.clear     = clear;
    assign bus.inc       = inc;
    assign bus.dec       = dec;
    assign bus.load      = load;
    assign bus.loadValue = loadValue;
    assign dCount[g]     = bus.count;
    assign dAtMax[g]     = bus.atMax;
    assign dAtZero[g]    = bus.atZero;
    assign dWp[g]        = bus.wrapPulse;
    assign dOv[g]        = bus.overflow;
    assign dUn[g]        = bus.underflow;
`ifdef PARAM_BIT_COUNTER_SNAPSHOT_EN
    assign bus.snap      = snap;
    assign dSnap[g]      = bus.snapshot;
`else
    assign dSnap[g]      = 8'd0;
`endif

    param_bit_counter #(
      .WIDTH    (8),
      .MAX_COUNT(mxOf(g)),
      .PRESCALE (preOf(g)),
      .SATURATE (satOf(g))
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  // Reference model state.
  int mCnt[N];
  int mPre[N];
  int mSnap[N];
  bit mOv[N];
  bit mUn[N];
  bit mWp[N];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Apply the counter rules to the inputs present at this edge.
  task automatic modelStep();
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        mCnt[i] = 0; mPre[i] = 0; mOv[i] = 0; mUn[i] = 0; mWp[i] = 0; mSnap[i] = 0;
      end else begin
        if (snap) mSnap[i] = mCnt[i];
        mWp[i] = 0;
        if (clear) begin
          mCnt[i] = 0; mPre[i] = 0; mOv[i] = 0; mUn[i] = 0;
        end else if (load) begin
          mCnt[i] = (int'(loadValue) > mxOf(i)) ? mxOf(i) : int'(loadValue);
          mPre[i] = 0;
        end else if (inc != dec) begin
          if (mPre[i] + 1 < preOf(i)) begin
            mPre[i]++;
          end else begin
            mPre[i] = 0;
            if (inc) begin
              if (mCnt[i] == mxOf(i)) begin
                mOv[i] = 1;
                if (!satOf(i)) begin mCnt[i] = 0; mWp[i] = 1; end
              end else mCnt[i]++;
            end else begin
              if (mCnt[i] == 0) begin
                mUn[i] = 1;
                if (!satOf(i)) begin mCnt[i] = mxOf(i); mWp[i] = 1; end
              end else mCnt[i]--;
            end
          end
        end
      end
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("count[%0d]", i), 32'(dCount[i]), 32'(mCnt[i]));
      chk($sformatf("atMax[%0d]", i), 32'(dAtMax[i]), 32'(mCnt[i] == mxOf(i)));
      chk($sformatf("atZero[%0d]", i), 32'(dAtZero[i]), 32'(mCnt[i] == 0));
      chk($sformatf("wrapPulse[%0d]", i), 32'(dWp[i]), 32'(mWp[i]));
      chk($sformatf("overflow[%0d]", i), 32'(dOv[i]), 32'(mOv[i]));
      chk($sformatf("underflow[%0d]", i), 32'(dUn[i]), 32'(mUn[i]));
`ifdef PARAM_BIT_COUNTER_SNAPSHOT_EN
      chk($sformatf("snapshot[%0d]", i), 32'(dSnap[i]), 32'(mSnap[i]));
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle();
    clear = 0; inc = 0; dec = 0; load = 0; snap = 0; loadValue = 8'd0;
  endtask

  initial begin
    reset = 0;
    idle();

    // Reset held low for two cycles.
    repeat (2) tick();
    chk("rst_count", 32'(dCount[0]), 32'd0);
    chk("rst_atZero", 32'(dAtZero[0]), 32'd1);
    chk("rst_atMax", 32'(dAtMax[0]), 32'd0);

    // Ten increments from zero on every configuration.
    reset = 1; inc = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) chk("inc1_atZero", 32'(dAtZero[0]), 32'd0);
      if (k == 9) begin
        chk("wrap_reach9", 32'(dCount[1]), 32'd9);
        chk("wrap_atMax", 32'(dAtMax[1]), 32'd1);
        chk("wrap_noPulseYet", 32'(dWp[1]), 32'd0);
      end
    end
    chk("inc10_count", 32'(dCount[0]), 32'd10);
    chk("wrap_count0", 32'(dCount[1]), 32'd0);
    chk("wrap_pulse", 32'(dWp[1]), 32'd1);
    chk("wrap_overflow", 32'(dOv[1]), 32'd1);
    chk("sat_hold9", 32'(dCount[2]), 32'd9);
    chk("pre3_count", 32'(dCount[3]), 32'd3);
    inc = 0;
    tick();
    chk("wrap_pulseOneCycle", 32'(dWp[1]), 32'd0);
    chk("wrap_ovSticky", 32'(dOv[1]), 32'd1);

    // Saturate: load 9, push up three times, then clear and push down.
    clear = 1; tick();
    chk("clear_ov", 32'(dOv[1]), 32'd0);
    clear = 0; load = 1; loadValue = 8'd9; tick();
    load = 0; inc = 1;
    repeat (3) tick();
    chk("sat_count", 32'(dCount[2]), 32'd9);
    chk("sat_noWrap", 32'(dWp[2]), 32'd0);
    chk("sat_overflow", 32'(dOv[2]), 32'd1);
    inc = 0; clear = 1; tick();
    clear = 0; dec = 1; tick();
    chk("sat_downHold", 32'(dCount[2]), 32'd0);
    chk("sat_underflow", 32'(dUn[2]), 32'd1);
    chk("wrap_down9", 32'(dCount[1]), 32'd9);
    chk("wrap_downPulse", 32'(dWp[1]), 32'd1);
    dec = 0;

    // Prescale 3: nine incs with one inc=dec cycle in the middle.
    clear = 1; tick(); clear = 0;
    for (int k = 0; k < 10; k++) begin
      inc = 1; dec = (k == 5);
      tick();
    end
    idle();
    chk("pre3_nineEvents", 32'(dCount[3]), 32'd3);
    chk("pre3_plainCount", 32'(dCount[0]), 32'd9);

    // Priority: clear beats load beats step; reset beats everything.
    clear = 1; load = 1; loadValue = 8'd5; inc = 1; tick();
    chk("prio_clearWins", 32'(dCount[1]), 32'd0);
    clear = 0; inc = 0; loadValue = 8'd200; tick();
    chk("prio_loadClamp", 32'(dCount[1]), 32'd9);
    chk("prio_loadNoClamp", 32'(dCount[0]), 32'd200);
    load = 0; reset = 0; inc = 1; tick();
    chk("prio_resetWins", 32'(dCount[0]), 32'd0);
    reset = 1; idle();

`ifdef PARAM_BIT_COUNTER_SNAPSHOT_EN
    // Snapshot captures the pre-update count; clear leaves it alone.
    clear = 1; tick(); clear = 0; inc = 1;
    repeat (4) tick();
    snap = 1; tick();
    chk("snap_value", 32'(dSnap[0]), 32'd4);
    chk("snap_countAfter", 32'(dCount[0]), 32'd5);
    snap = 0; inc = 0; clear = 1; tick();
    chk("snap_afterClear", 32'(dSnap[0]), 32'd4);
    idle();
`endif

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 199) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      load      = ($urandom_range(0, 29) == 0);
      loadValue = 8'($urandom_range(0, 255));
      snap      = ($urandom_range(0, 9) == 0);
      inc       = ($urandom_range(0, 2) != 0) ^ (k[8]);
      dec       = ($urandom_range(0, 2) == 0) ^ (k[8]);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
